// File: rtl/instr_controller.sv
// Sequencing controller for the 10-bit datapath: latches an instruction on EXEC and
// drives one-hot register, bus and ALU controls per timestep of the upstream counter.
module instr_controller (
    input  logic       CLKb,
    input  logic       CLR,
    input  logic       EXEC,
    input  logic [9:0] DIN,
    input  logic [1:0] T,
    output logic       CLR_T,
    output logic       BUSY,
    output logic       IR_en,
    output logic [3:0] Rin,
    output logic [3:0] Rout,
    output logic       A_en,
    output logic       G_en,
    output logic       G_out,
    output logic       Ext_out,
    output logic       ALU_sub,
    output logic       DONE,
    output logic       ILLEGAL
);

    typedef enum logic [0:0] {
        StIdle,
        StExec
    } state_e;

    localparam logic [3:0] OpLoad = 4'b0000;
    localparam logic [3:0] OpMov  = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpSub  = 4'b0011;

    state_e     state_q, state_d;
    logic [9:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic [3:0] rx_oh;
    logic [3:0] ry_oh;
    logic       unused_ir;

    function automatic logic [3:0] dec_sel(input logic [1:0] sel);
        logic [3:0] oh;
        unique case (sel)
            2'd0: oh = 4'b0001;
            2'd1: oh = 4'b0010;
            2'd2: oh = 4'b0100;
            2'd3: oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    assign opcode    = ir_q[9:6];
    assign rx_oh     = dec_sel(ir_q[5:4]);
    assign ry_oh     = dec_sel(ir_q[3:2]);
    assign unused_ir = ^ir_q[1:0];

    // State register; updates on the falling edge to line up with the timestep counter.
    always_ff @(negedge CLKb) begin
        if (CLR) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StIdle: begin
                if (EXEC) begin
                    state_d = StExec;
                    ir_d    = DIN;
                end
            end
            StExec: begin
                if (DONE) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign BUSY  = (state_q == StExec);
    assign CLR_T = (state_q == StIdle);

    always_comb begin
        IR_en   = 1'b0;
        Rin     = 4'b0000;
        Rout    = 4'b0000;
        A_en    = 1'b0;
        G_en    = 1'b0;
        G_out   = 1'b0;
        Ext_out = 1'b0;
        ALU_sub = 1'b0;
        DONE    = 1'b0;
        ILLEGAL = 1'b0;
        if (!CLR) begin
            unique case (state_q)
                StIdle: IR_en = EXEC;
                StExec: begin
                    // T=3 can only mean the counter ran past the instruction: abort it.
                    if (T == 2'd3) begin
                        DONE    = 1'b1;
                        ILLEGAL = 1'b1;
                    end else begin
                        case (opcode)
                            OpLoad: begin
                                if (T == 2'd0) begin
                                    Ext_out = 1'b1;
                                    Rin     = rx_oh;
                                    DONE    = 1'b1;
                                end
                            end
                            OpMov: begin
                                if (T == 2'd0) begin
                                    Rout = ry_oh;
                                    Rin  = rx_oh;
                                    DONE = 1'b1;
                                end
                            end
                            OpAdd, OpSub: begin
                                unique case (T)
                                    2'd0: begin
                                        Rout = rx_oh;
                                        A_en = 1'b1;
                                    end
                                    2'd1: begin
                                        Rout    = ry_oh;
                                        G_en    = 1'b1;
                                        ALU_sub = (opcode == OpSub);
                                    end
                                    2'd2: begin
                                        G_out = 1'b1;
                                        Rin   = rx_oh;
                                        DONE  = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                            default: begin
                                if (T == 2'd0) begin
                                    DONE    = 1'b1;
                                    ILLEGAL = 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller: directed vector table, hand sequences for abort/overrun,
// then random traffic against a step-table reference model with a modelled timestep counter.
module tb_instr_controller;

    logic       CLKb = 1'b1;
    logic       CLR, EXEC;
    logic [9:0] DIN;
    logic [1:0] T;
    logic       CLR_T, BUSY, IR_en, A_en, G_en, G_out, Ext_out, ALU_sub, DONE, ILLEGAL;
    logic [3:0] Rin, Rout;

    always #5 CLKb = ~CLKb;

    instr_controller dut (
        .CLKb    (CLKb),
        .CLR     (CLR),
        .EXEC    (EXEC),
        .DIN     (DIN),
        .T       (T),
        .CLR_T   (CLR_T),
        .BUSY    (BUSY),
        .IR_en   (IR_en),
        .Rin     (Rin),
        .Rout    (Rout),
        .A_en    (A_en),
        .G_en    (G_en),
        .G_out   (G_out),
        .Ext_out (Ext_out),
        .ALU_sub (ALU_sub),
        .DONE    (DONE),
        .ILLEGAL (ILLEGAL)
    );

    typedef struct packed {
        logic       ir_en;
        logic [3:0] rin;
        logic [3:0] rout;
        logic       a_en;
        logic       g_en;
        logic       g_out;
        logic       ext_out;
        logic       alu_sub;
        logic       done;
        logic       illegal;
        logic       busy;
        logic       clr_t;
    } ctl_t;

    typedef struct {
        string      name;
        logic       clr;
        logic       exec;
        logic [9:0] din;
        logic [1:0] t;
        ctl_t       exp;
    } vec_t;

    localparam logic [9:0] InsLoad = 10'b0000_10_00_00;
    localparam logic [9:0] InsAdd  = 10'b0010_01_11_00;
    localparam logic [9:0] InsSub  = 10'b0011_00_01_00;
    localparam logic [9:0] InsMov  = 10'b0001_11_10_00;
    localparam logic [9:0] InsIll  = 10'b1111_00_00_00;
    localparam logic [9:0] Junk    = 10'b1111_11_11_11;

    vec_t vecs[$];
    int   checks = 0;
    int   passes = 0;

    function automatic ctl_t mk(input logic ir_en, input logic [3:0] rin, input logic [3:0] rout,
                                input logic a_en, input logic g_en, input logic g_out,
                                input logic ext_out, input logic alu_sub, input logic done,
                                input logic illegal, input logic busy);
        ctl_t c;
        c = '{ir_en, rin, rout, a_en, g_en, g_out, ext_out, alu_sub, done, illegal, busy, !busy};
        return c;
    endfunction

    function automatic ctl_t actual();
        ctl_t c;
        c = '{IR_en, Rin, Rout, A_en, G_en, G_out, Ext_out, ALU_sub, DONE, ILLEGAL, BUSY, CLR_T};
        return c;
    endfunction

    // Reference: each opcode is a list of steps indexed by timestep.
    function automatic ctl_t model_out(input logic clr, input logic exec, input logic busy,
                                       input logic [9:0] ir, input logic [1:0] t);
        ctl_t       e;
        logic [3:0] rx, ry;
        int         op, steps;
        e       = '0;
        e.busy  = busy;
        e.clr_t = !busy;
        if (clr) return e;
        if (!busy) begin
            e.ir_en = exec;
            return e;
        end
        op    = int'(ir[9:6]);
        rx    = 4'b0001 << ir[5:4];
        ry    = 4'b0001 << ir[3:2];
        steps = (op == 2 || op == 3) ? 3 : 1;
        if (t == 2'd3) begin
            e.done    = 1'b1;
            e.illegal = 1'b1;
        end else if (op > 3) begin
            e.done    = (t == 2'd0);
            e.illegal = (t == 2'd0);
        end else if (int'(t) < steps) begin
            e.done = (int'(t) == steps - 1);
            if (op == 0) begin
                e.ext_out = 1'b1;
                e.rin     = rx;
            end else if (op == 1) begin
                e.rout = ry;
                e.rin  = rx;
            end else if (t == 2'd0) begin
                e.rout = rx;
                e.a_en = 1'b1;
            end else if (t == 2'd1) begin
                e.rout    = ry;
                e.g_en    = 1'b1;
                e.alu_sub = (op == 3);
            end else begin
                e.g_out = 1'b1;
                e.rin   = rx;
            end
        end
        return e;
    endfunction

    task automatic add(input string name, input logic clr, input logic exec,
                       input logic [9:0] din, input logic [1:0] t, input ctl_t exp);
        vec_t v;
        v.name = name;
        v.clr  = clr;
        v.exec = exec;
        v.din  = din;
        v.t    = t;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic clr, input logic exec, input logic [9:0] din,
                         input logic [1:0] t);
        CLR  = clr;
        EXEC = exec;
        DIN  = din;
        T    = t;
        #2;
    endtask

    task automatic check(input string name, input ctl_t exp);
        ctl_t act;
        int   drivers;
        act = actual();
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b required %b", name, act, exp);
        drivers = $countones(Rout) + int'(G_out) + int'(Ext_out);
        checks++;
        if (drivers <= 1) passes++;
        else $display("FAIL %s bus_drivers: got %0d required <=1", name, drivers);
    endtask

    task automatic edge_only();
        @(negedge CLKb);
        #1;
    endtask

    // Upstream counter: synchronous clear from CLR_T, otherwise wraps upward.
    task automatic edge_count();
        logic c;
        c = CLR_T;
        @(negedge CLKb);
        #1;
        T = c ? 2'd0 : T + 2'd1;
    endtask

    initial begin
        ctl_t       e;
        logic       mbusy;
        logic [9:0] mir;
        logic       rclr, rexec;
        logic [9:0] rdin;

        CLR  = 1'b1;
        EXEC = 1'b0;
        DIN  = '0;
        T    = 2'd0;
        edge_only();
        edge_only();

        add("reset",      1, 1, Junk,    0, mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("load_fetch", 0, 1, InsLoad, 0, mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("load_t0",    0, 0, Junk,    0, mk(0, 4'b0100, 4'b0000, 0, 0, 0, 1, 0, 1, 0, 1));
        add("load_idle",  0, 0, Junk,    1, mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("add_fetch",  0, 1, InsAdd,  0, mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("add_t0",     0, 0, Junk,    0, mk(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 1));
        add("add_t1",     0, 0, Junk,    1, mk(0, 4'b0000, 4'b1000, 0, 1, 0, 0, 0, 0, 0, 1));
        add("add_t2",     0, 0, Junk,    2, mk(0, 4'b0010, 4'b0000, 0, 0, 1, 0, 0, 1, 0, 1));
        add("add_idle",   0, 0, Junk,    3, mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sub_fetch",  0, 1, InsSub,  0, mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("sub_t0",     0, 1, Junk,    0, mk(0, 4'b0000, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 1));
        add("sub_t1",     0, 1, Junk,    1, mk(0, 4'b0000, 4'b0010, 0, 1, 0, 0, 1, 0, 0, 1));
        add("sub_t2",     0, 1, Junk,    2, mk(0, 4'b0001, 4'b0000, 0, 0, 1, 0, 0, 1, 0, 1));
        add("b2b_fetch",  0, 1, InsMov,  3, mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("mov_t0",     0, 1, Junk,    0, mk(0, 4'b1000, 4'b0100, 0, 0, 0, 0, 0, 1, 0, 1));
        add("ill_fetch",  0, 1, InsIll,  1, mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        add("ill_t0",     0, 0, Junk,    0, mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 1));
        add("ill_idle",   0, 0, Junk,    1, mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].exec, vecs[i].din, vecs[i].t);
            check(vecs[i].name, vecs[i].exp);
            edge_only();
        end

        // Reset during T1 of ADD: controls forced off, no Rin pulse afterwards.
        drive(0, 1, InsAdd, 0);
        check("abort_fetch", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_only();
        drive(0, 0, Junk, 0);
        check("abort_t0", mk(0, 4'b0000, 4'b0010, 1, 0, 0, 0, 0, 0, 0, 1));
        edge_only();
        drive(1, 0, Junk, 1);
        check("abort_clr", mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
        edge_only();
        drive(0, 0, Junk, 2);
        check("abort_idle", mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_only();

        // Counter overrun while executing LOAD.
        drive(0, 1, InsLoad, 0);
        check("ovr_fetch", mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_only();
        drive(0, 0, Junk, 3);
        check("ovr_t3", mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 1));
        edge_only();
        drive(0, 0, Junk, 0);
        check("ovr_idle", mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        edge_only();

        mbusy = 1'b0;
        mir   = '0;
        T     = 2'd0;
        for (int n = 0; n < 600; n++) begin
            rclr  = ($urandom_range(0, 29) == 0);
            rexec = 1'($urandom_range(0, 1));
            rdin  = {4'($urandom_range(0, 7)), 6'($urandom)};
            if ($urandom_range(0, 39) == 0) T = 2'($urandom_range(0, 3));
            CLR  = rclr;
            EXEC = rexec;
            DIN  = rdin;
            #2;
            e = model_out(rclr, rexec, mbusy, mir, T);
            check($sformatf("rand[%0d] ir=%b t=%0d", n, mir, T), e);
            if (rclr) begin
                mbusy = 1'b0;
                mir   = '0;
            end else if (!mbusy && rexec) begin
                mbusy = 1'b1;
                mir   = rdin;
            end else if (mbusy && e.done) begin
                mbusy = 1'b0;
            end
            edge_count();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
# instr_controller

Sequencing controller for the 10-bit processor datapath. It sits directly downstream of the 2-bit timestep counter: it consumes the counter value `T`, holds the counter cleared while idle, and releases it while an instruction executes. On `EXEC` it latches a 10-bit instruction, decodes it, and drives one-hot register, bus, and ALU controls for each timestep. It owns the counter's clear line `CLR_T`, clears it at instruction end, and pulses `DONE`.

## Interface
- No parameters. Widths are fixed: instruction 10, register select 4 one-hot, timestep 2.
- `CLKb`  in  1  system clock. All state updates on the falling edge, matching the timestep counter.
- `CLR`  in  1  synchronous, active-high reset, sampled on the `CLKb` falling edge.
- `EXEC`  in  1  start request, sampled while idle.
- `DIN`  in  10  instruction word, captured into `IR` on an accepted start.
- `T`  in  2  timestep from the upstream counter.
- `CLR_T`  out  1  registered clear to the timestep counter. High while idle.
- `BUSY`  out  1  registered. High while an instruction executes.
- `IR_en`  out  1  instruction-register load strobe (fetch cycle).
- `Rin`  out  4  one-hot register write enables.
- `Rout`  out  4  one-hot register bus drivers.
- `A_en`, `G_en`, `G_out`, `Ext_out`  out  1 each  ALU operand latch, ALU result latch, result-to-bus, external-data-to-bus.
- `ALU_sub`  out  1  0 = add, 1 = subtract.
- `DONE`  out  1  high in the final timestep of an instruction.
- `ILLEGAL`  out  1  high with `DONE` for an unsupported opcode.

## Operation
- **Instruction fields:**
  - `IR[9:6]` is the opcode.
  - `IR[5:4]` is `Rx`, the destination and first operand.
  - `IR[3:2]` is `Ry`.
  - `IR[1:0]` is ignored.
- **Register selects:** `Rin`/`Rout` are decoded one-hot from the 2-bit `Rx`/`Ry` fields (0 → `0001`, 3 → `1000`).
- **States:**
  - IDLE: `BUSY`=0, `CLR_T`=1.
  - EXEC: `BUSY`=1, `CLR_T`=0.
- **IDLE, fetch:**
  - With `EXEC`=1, `IR_en`=1 combinationally.
  - On the next edge: `IR`←`DIN`, go to EXEC.
  - With `EXEC`=0, stay in IDLE; all outputs except `CLR_T` are 0.
- **EXEC decode:** combinational from (`IR`, `T`). Opcodes:
  - 0000 LOAD: T0: `Ext_out`, `Rin[Rx]`, `DONE`.
  - 0001 MOV: T0: `Rout[Ry]`, `Rin[Rx]`, `DONE`.
  - 0010 ADD:
    - T0: `Rout[Rx]`, `A_en`.
    - T1: `Rout[Ry]`, `G_en`.
    - T2: `G_out`, `Rin[Rx]`, `DONE`.
  - 0011 SUB: same as ADD, with `ALU_sub`=1 in T1.
  - Any other opcode: T0: `DONE`, `ILLEGAL`. No register or bus activity.
- **Completion:** on an edge where `DONE`=1, go to IDLE (`BUSY`←0, `CLR_T`←1).
- **Overrun guard:** `T`=3 in EXEC is never a legal step.
  - That cycle drives `DONE`=1, `ILLEGAL`=1 and no other controls.
  - The controller then returns to IDLE.
- **Ignored inputs:** `EXEC` is ignored while `BUSY`=1, and `DIN` is ignored except in the fetch cycle.
- **At most one bus driver:** at most one of `Rout`, `G_out`, `Ext_out` is active in any cycle. This is an invariant; the bench asserts it.

## Timing
- **Reset:**
  - `CLR`=1 at an edge sets `BUSY`=0, `CLR_T`=1, `IR`=0.
  - While `CLR`=1, all combinational outputs are forced to 0, including `IR_en` and `DONE`.
- **Reset mid-instruction:** abort with no further writes. The next cycle is IDLE.
- **Start:** accepted at edge E0 (IDLE, `EXEC`=1). T0 spans E0→E1; the counter advances `T` at each following edge.
- **Latency, fetch cycle to last step inclusive:**
  - LOAD, MOV, illegal opcode: 2 cycles.
  - ADD, SUB: 4 cycles.
- **Back-to-back:** after `DONE`, at least one IDLE cycle is required. `EXEC` held high starts the next instruction on the edge following the `DONE` edge.
- **`CLR_T` rises after the `DONE` edge.** `T` is don't-care while IDLE.

## Test plan
- **Reset:** `CLR`=1 for 2 edges.
  - Required: `BUSY`=0, `CLR_T`=1, `IR`=0.
  - Required: all control outputs 0, even with `EXEC`=1.
- **LOAD:** `DIN`=`0000_10_00_00`, `EXEC` pulse.
  - Fetch: `IR_en`=1.
  - Next cycle: `Ext_out`=1, `Rin`=`0100`, `DONE`=1.
  - Then `CLR_T`=1.
- **ADD:** `DIN`=`0010_01_11_00`.
  - T0: `Rout`=`0010`, `A_en`=1.
  - T1: `Rout`=`1000`, `G_en`=1, `ALU_sub`=0.
  - T2: `G_out`=1, `Rin`=`0010`, `DONE`=1.
- **SUB, then held `EXEC`:** `DIN`=`0011_00_01_00`, `EXEC` held high throughout.
  - `ALU_sub`=1 only in T1.
  - Second fetch (`IR_en`) occurs exactly one cycle after the `DONE` cycle.
  - `EXEC` during `BUSY` does not disturb `IR`.
- **Illegal opcode:** `DIN`=`1111_00_00_00`.
  - Next cycle: `DONE`=1, `ILLEGAL`=1, `Rin`/`Rout`=0.
  - Then IDLE.
- **Reset mid-instruction and overrun:**
  - Reset: assert `CLR` during T1 of ADD. Required: no `Rin` pulse, IDLE next cycle.
  - Overrun: separately, force `T`=3 while in EXEC. Required: `DONE`=`ILLEGAL`=1, then `BUSY`=0.
